// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle RV32I control path:
// FSM states, opcodes, ALU opcodes and datapath select codes.
package core_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_R,
        CLS_I
    } alu_cls_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [6:0] F7_ZERO = 7'h00;

    localparam logic [9:0] ALU_ADD  = 10'h000;
    localparam logic [9:0] ALU_SUB  = 10'h100;
    localparam logic [9:0] ALU_SLL  = 10'h001;
    localparam logic [9:0] ALU_SLT  = 10'h002;
    localparam logic [9:0] ALU_SLTU = 10'h003;
    localparam logic [9:0] ALU_XOR  = 10'h004;
    localparam logic [9:0] ALU_SRL  = 10'h005;
    localparam logic [9:0] ALU_SRA  = 10'h105;
    localparam logic [9:0] ALU_OR   = 10'h006;
    localparam logic [9:0] ALU_AND  = 10'h007;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic alu_in_table(input logic [9:0] c);
        logic ok;
        ok = 1'b0;
        case (c)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_sequencer_fsm_if.sv
// Instruction fields and status in, ALU/datapath controls out.
interface alu_sequencer_fsm_if;
    import core_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic [9:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output alu_ctrl, alu_src_a, alu_src_b, result_src,
        output adr_src, ir_write, pc_write, mem_write, reg_write, illegal
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  alu_ctrl, alu_src_a, alu_src_b, result_src,
        input  adr_src, ir_write, pc_write, mem_write, reg_write, illegal
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Maps the current ALU usage class and funct fields to the ALU opcode
// and flags encodings the core does not implement.
module alu_op_decoder
    import core_pkg::*;
(
    input  alu_cls_e   cls_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [9:0] alu_ctrl_o,
    output logic       legal_o
);

    logic [6:0] i_f7;
    logic [6:0] i_chk_f7;

    // Only shifts carry meaning in the I-type upper bits.
    assign i_f7     = (funct3_i == F3_SR) ? funct7_i : F7_ZERO;
    assign i_chk_f7 = (funct3_i == F3_SR || funct3_i == F3_SLL)
                    ? funct7_i : F7_ZERO;

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
        unique case (cls_i)
            CLS_ADD: alu_ctrl_o = ALU_ADD;
            CLS_SUB: alu_ctrl_o = ALU_SUB;
            CLS_R: begin
                alu_ctrl_o = {funct7_i, funct3_i};
                legal_o    = alu_in_table({funct7_i, funct3_i});
            end
            CLS_I: begin
                alu_ctrl_o = {i_f7, funct3_i};
                legal_o    = alu_in_table({i_chk_f7, funct3_i});
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences the shared
// ALU and drives all datapath selects and write enables.
module alu_sequencer_fsm
    import core_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    alu_sequencer_fsm_if.master bus
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    alu_cls_e   cls;
    logic       legal;
    logic [9:0] alu_ctrl;
    logic [1:0] src_a, src_b, res_src;
    logic       adr, irw, pcw, mw, rw;

    alu_op_decoder u_dec (
        .cls_i      (cls),
        .funct3_i   (bus.funct3),
        .funct7_i   (bus.funct7),
        .alu_ctrl_o (alu_ctrl),
        .legal_o    (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls     = CLS_ADD;
        src_a   = SRCA_PC;
        src_b   = SRCB_RS2;
        res_src = RES_ALUOUT;
        adr     = 1'b0;
        irw     = 1'b0;
        pcw     = 1'b0;
        mw      = 1'b0;
        rw      = 1'b0;
        case (state_q)
            S_FETCH: begin
                src_b   = SRCB_FOUR;
                res_src = RES_ALU;
                irw     = bus.mem_ready;
                pcw     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_src = RES_MEM;
                rw      = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                adr = 1'b1;
                mw  = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                src_a   = SRCA_RS1;
                cls     = CLS_R;
                state_d = legal ? S_ALUWB : S_TRAP;
            end
            S_EXEC_I: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                cls     = CLS_I;
                state_d = legal ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                rw      = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_a = SRCA_RS1;
                cls   = CLS_SUB;
                if (bus.funct3 == F3_BEQ) begin
                    pcw     = bus.zero;
                    state_d = S_FETCH;
                end else if (bus.funct3 == F3_BNE) begin
                    pcw     = ~bus.zero;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_JAL: begin
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_FOUR;
                pcw     = 1'b1;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    // Enables are masked so an access is dropped the moment reset rises.
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.alu_src_a  = src_a;
    assign bus.alu_src_b  = src_b;
    assign bus.result_src = res_src;
    assign bus.adr_src    = adr;
    assign bus.ir_write   = irw & ~reset;
    assign bus.pc_write   = pcw & ~reset;
    assign bus.mem_write  = mw & ~reset;
    assign bus.reg_write  = rw & ~reset;
    assign bus.illegal    = illegal_q & ~reset;

endmodule

// File: tb/tb_alu_sequencer_fsm.sv
// Cycle-by-cycle vector bench for the multicycle control FSM.
module tb_alu_sequencer_fsm;
    import core_pkg::*;

    typedef struct packed {
        logic [9:0] ctrl;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       mw;
        logic       rw;
        logic       ill;
    } out_t;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        zero;
        logic        mr;
        out_t        exp;
        int          grp;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    step_t steps[$];
    out_t  sb[$];

    alu_sequencer_fsm_if bus ();

    alu_sequencer_fsm u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(logic [9:0] c, logic [1:0] a, logic [1:0] b,
                                logic [1:0] rs, logic adr, logic irw,
                                logic pcw, logic mw, logic rw, logic ill);
        out_t o;
        o = '{c, a, b, rs, adr, irw, pcw, mw, rw, ill};
        return o;
    endfunction

    function automatic out_t o_rst();
        return mk(10'h000, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t o_f(logic m);
        return mk(10'h000, 2'b00, 2'b10, 2'b10, 0, m, m, 0, 0, 0);
    endfunction
    function automatic out_t o_d();
        return mk(10'h000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t o_ma();
        return mk(10'h000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t o_mr();
        return mk(10'h000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t o_mwb();
        return mk(10'h000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0);
    endfunction
    function automatic out_t o_mw();
        return mk(10'h000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0);
    endfunction
    function automatic out_t o_er(logic [9:0] c);
        return mk(c, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t o_ei(logic [9:0] c);
        return mk(c, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t o_wb();
        return mk(10'h000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
    endfunction
    function automatic out_t o_br(logic p);
        return mk(10'h100, 2'b10, 2'b00, 2'b00, 0, 0, p, 0, 0, 0);
    endfunction
    function automatic out_t o_jal();
        return mk(10'h000, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0);
    endfunction
    function automatic out_t o_trap();
        return mk(10'h000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic out_t sample();
        return mk(bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b,
                  bus.result_src, bus.adr_src, bus.ir_write,
                  bus.pc_write, bus.mem_write, bus.reg_write,
                  bus.illegal);
    endfunction

    task automatic add(logic r, logic [31:0] ins, logic z, logic m,
                       out_t e, int g);
        step_t s;
        s.rst = r; s.ins = ins; s.zero = z; s.mr = m; s.exp = e; s.grp = g;
        steps.push_back(s);
    endtask

    task automatic check(out_t got, string nm, int idx);
        out_t e;
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s idx %0d got %h required %h", nm, idx, got, e);
        end
    endtask

    task automatic run_step(step_t s, int idx);
        @(negedge clk);
        rst           = s.rst;
        bus.opcode    = s.ins[6:0];
        bus.funct3    = s.ins[14:12];
        bus.funct7    = s.ins[31:25];
        bus.zero      = s.zero;
        bus.mem_ready = s.mr;
        sb.push_back(s.exp);
        #2;
        check(sample(), $sformatf("grp%0d", s.grp), idx);
    endtask

    localparam logic [31:0] I_ADD  = 32'h00208033;
    localparam logic [31:0] I_SUB  = 32'h40208033;
    localparam logic [31:0] I_SRA  = 32'h4020D033;
    localparam logic [31:0] I_SRAI = 32'h4020D013;
    localparam logic [31:0] I_SLT  = 32'h0020A033;
    localparam logic [31:0] I_ADDI = 32'h00108093;
    localparam logic [31:0] I_XORI = 32'hFFF0C093;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_BLT  = 32'h0020C063;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_MUL  = 32'h02208033;
    localparam logic [31:0] I_BSRL = 32'h2020D013;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    task automatic alu4(logic [31:0] ins, out_t ex, int g);
        add(0, ins, 0, 1, o_f(1), g);
        add(0, ins, 0, 1, o_d(), g);
        add(0, ins, 0, 1, ex, g);
        add(0, ins, 0, 1, o_wb(), g);
    endtask

    task automatic br3(logic [31:0] ins, logic z, logic p, int g);
        add(0, ins, ~z, 1, o_f(1), g);
        add(0, ins, ~z, 1, o_d(), g);
        add(0, ins, z, 1, o_br(p), g);
    endtask

    initial begin
        out_t got;
        bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;

        add(1, I_ADD, 0, 1, o_rst(), 0);
        alu4(I_ADD,  o_er(10'h000), 1);
        alu4(I_SUB,  o_er(10'h100), 2);
        alu4(I_SRA,  o_er(10'h105), 2);
        alu4(I_SRAI, o_ei(10'h105), 2);
        alu4(I_SLT,  o_er(10'h002), 2);
        alu4(I_ADDI, o_ei(10'h000), 2);
        alu4(I_XORI, o_ei(10'h004), 2);
        br3(I_BEQ, 1, 1, 3);
        br3(I_BEQ, 0, 0, 3);
        br3(I_BNE, 1, 0, 3);
        br3(I_BNE, 0, 1, 3);
        for (int i = 0; i < 3; i++) add(0, I_LW, 0, 0, o_f(0), 4);
        add(0, I_LW, 0, 1, o_f(1), 4);
        add(0, I_LW, 0, 0, o_d(), 4);
        add(0, I_LW, 0, 0, o_ma(), 4);
        for (int i = 0; i < 3; i++) add(0, I_LW, 0, 0, o_mr(), 4);
        add(0, I_LW, 0, 1, o_mr(), 4);
        add(0, I_LW, 0, 0, o_mwb(), 4);
        add(0, I_SW, 0, 1, o_f(1), 5);
        add(0, I_SW, 0, 0, o_d(), 5);
        add(0, I_SW, 0, 0, o_ma(), 5);
        add(0, I_SW, 0, 0, o_mw(), 5);
        add(0, I_SW, 0, 1, o_mw(), 5);
        alu4(I_JAL, o_jal(), 6);
        add(0, I_MUL, 0, 1, o_f(1), 7);
        add(0, I_MUL, 0, 1, o_d(), 7);
        add(0, I_MUL, 0, 1, o_er(10'h008), 7);
        add(0, I_MUL, 0, 1, o_trap(), 7);
        add(1, I_MUL, 0, 1, o_rst(), 7);
        add(0, I_BSRL, 0, 1, o_f(1), 8);
        add(0, I_BSRL, 0, 1, o_d(), 8);
        add(0, I_BSRL, 0, 1, o_ei(10'h085), 8);
        add(0, I_BSRL, 0, 1, o_trap(), 8);
        add(1, I_BSRL, 0, 1, o_rst(), 8);
        br3(I_BLT, 1, 0, 9);
        add(0, I_BLT, 0, 1, o_trap(), 9);
        add(1, I_BLT, 0, 1, o_rst(), 9);
        add(0, I_ILL, 0, 1, o_f(1), 10);
        add(0, I_ILL, 0, 1, o_d(), 10);
        add(0, I_ILL, 0, 1, o_trap(), 10);
        add(0, I_ADD, 0, 1, o_trap(), 10);
        add(0, I_ILL, 1, 0, o_trap(), 10);
        add(1, I_ILL, 0, 1, o_rst(), 10);
        add(0, I_ADD, 0, 1, o_f(1), 11);
        add(0, I_ADD, 0, 1, o_d(), 11);

        for (int i = 0; i < steps.size(); i++) run_step(steps[i], i);

        // Reset dropped into the middle of a store access.
        steps.delete();
        add(0, I_ADD, 0, 1, o_er(10'h000), 12);
        add(0, I_ADD, 0, 1, o_wb(), 12);
        add(0, I_SW, 0, 1, o_f(1), 12);
        add(0, I_SW, 0, 1, o_d(), 12);
        add(0, I_SW, 0, 1, o_ma(), 12);
        add(0, I_SW, 0, 0, o_mw(), 12);
        for (int i = 0; i < steps.size(); i++) run_step(steps[i], 100 + i);
        @(posedge clk);
        #1;
        sb.push_back(o_mw());
        check(sample(), "mw_hold", 200);
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        sb.push_back(o_rst());
        check(sample(), "async_rst", 201);
        steps.delete();
        add(1, I_SW, 0, 1, o_rst(), 13);
        add(0, I_SW, 0, 1, o_f(1), 13);
        add(0, I_SW, 0, 1, o_d(), 13);
        for (int i = 0; i < steps.size(); i++) run_step(steps[i], 300 + i);

        got = sample();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
